icache_assoc: RTL

Two-way set-associative, multi-word-line instruction cache that replaces the direct-mapped single-word ICache in the fetch stage. It serves hits combinationally and stalls fetch on a miss. On a miss it fills a whole line from instruction memory through a req/ready handshake, one word per beat. Victims are chosen by invalid-first, then per-set LRU. Fills can be aborted by branch mispredict or flush.

---
 rtl/icache_assoc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Two-way set-associative instruction cache with multi-word lines and a req/ready line fill.
// Define ICACHE_STATS_EN to add the hit_cnt / miss_cnt statistics outputs.
module icache_assoc #(
    parameter int INDEX_WID  = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WID   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        predict_fail,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_WID  = $clog2(LINE_WORDS);
    localparam int LSB_IDX  = OFF_WID + 2;
    localparam int LSB_TAG  = INDEX_WID + OFF_WID + 2;
    localparam int TAG_WID  = ADDR_WID - LSB_TAG;
    localparam int LINE_WID = ADDR_WID - LSB_IDX;
    localparam int SETS     = 1 << INDEX_WID;
    localparam logic [OFF_WID-1:0] LAST_BEAT = OFF_WID'(LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_nxt;

    logic [31:0]          data_arr [SETS][2][LINE_WORDS];
    logic [TAG_WID-1:0]   tag_arr  [SETS][2];
    logic [SETS-1:0]      vld_w0, vld_w1, lru;
    logic [31:0]          line_buf [LINE_WORDS];

    logic [LINE_WID-1:0]  fill_line;
    logic                 fill_way;
    logic [OFF_WID-1:0]   beat;

    logic [INDEX_WID-1:0] set_idx;
    logic [OFF_WID-1:0]   word_off;
    logic [TAG_WID-1:0]   tag;
    logic [INDEX_WID-1:0] fill_set;
    logic [TAG_WID-1:0]   fill_tag;
    logic                 hit0, hit1, hit;
    logic                 victim;
    logic                 start_fill, beat_done, install, lru_upd;
    logic                 unused_addr;

    assign set_idx  = addr[LSB_TAG-1:LSB_IDX];
    assign word_off = addr[LSB_IDX-1:2];
    assign tag      = addr[ADDR_WID-1:LSB_TAG];
    assign fill_set = fill_line[INDEX_WID-1:0];
    assign fill_tag = fill_line[LINE_WID-1:INDEX_WID];

    // Word-alignment bits and PC bits above ADDR_WID never take part in the lookup.
    assign unused_addr = ^{addr[31:ADDR_WID], addr[1:0]};

    assign hit0 = vld_w0[set_idx] && (tag_arr[set_idx][0] == tag);
    assign hit1 = vld_w1[set_idx] && (tag_arr[set_idx][1] == tag);
    assign hit  = hit0 || hit1;

    assign inst         = data_arr[set_idx][hit1][word_off];
    assign icache_stall = !predict_fail && !hit;
    assign mem_addr     = {{(32-ADDR_WID){1'b0}}, fill_line, beat, 2'b00};
    assign lru_upd      = (state == IDLE) && hit && !predict_fail;

    always_comb begin
        victim = lru[set_idx];
        if (!vld_w0[set_idx]) begin
            victim = 1'b0;
        end else if (!vld_w1[set_idx]) begin
            victim = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        start_fill = 1'b0;
        beat_done  = 1'b0;
        install    = 1'b0;
        case (state)
            IDLE: begin
                if (icache_stall && !flush) begin
                    state_nxt  = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                // A mispredict or flush withdraws the request in the same cycle.
                if (predict_fail || flush) begin
                    state_nxt = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        beat_done = 1'b1;
                        if (beat == LAST_BEAT) begin
                            install   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            vld_w0 <= '0;
            vld_w1 <= '0;
            lru    <= '0;
        end else begin
            state <= state_nxt;
            if (start_fill) begin
                beat <= '0;
            end else if (beat_done) begin
                beat <= beat + 1'b1;
            end
            if (flush) begin
                vld_w0 <= '0;
                vld_w1 <= '0;
                lru    <= '0;
            end else if (install) begin
                if (fill_way) begin
                    vld_w1[fill_set] <= 1'b1;
                end else begin
                    vld_w0[fill_set] <= 1'b1;
                end
                lru[fill_set] <= ~fill_way;
            end else if (lru_upd) begin
                lru[set_idx] <= hit0;
            end
        end
    end

    // Data path: tags, line words and the fill buffer carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (start_fill) begin
            fill_line <= addr[ADDR_WID-1:LSB_IDX];
            fill_way  <= victim;
        end
        if (beat_done) begin
            line_buf[beat] <= mem_data;
        end
        if (install) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_arr[fill_set][fill_way][i] <= (i == LINE_WORDS - 1) ? mem_data : line_buf[i];
            end
            tag_arr[fill_set][fill_way] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lru_upd) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_fill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
